// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: read-side master for an 8-bit FIFO read port.
// Takes a burst request of N bytes, issues active-low read strobes while the
// output buffer has room, retries strobes rejected with underflow, and streams
// the returned bytes downstream on valid/ready with a last marker.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 5,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  req_ready,
    output logic                  fifo_rd_n,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_under_flow,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            uf_cnt
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  to_issue_q, to_issue_d;
    logic [LEN_WIDTH-1:0]  to_deliver_q, to_deliver_d;
    logic                  inflight_q, inflight_d;
    logic [7:0]            uf_cnt_q, uf_cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] buf_data_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_data_d [BUF_DEPTH];
    logic                  buf_last_q [BUF_DEPTH];
    logic                  buf_last_d [BUF_DEPTH];

    logic [CNT_W:0]        occupancy;
    logic                  rd_strobe;
    logic                  resp_ok;
    logic                  resp_retry;
    logic                  head_valid;
    logic                  head_last;
    logic                  pop;

    // Space reserved for the byte already requested keeps the buffer from overflowing.
    assign occupancy  = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
    assign rd_strobe  = (state_q == ST_READ) && (to_issue_q != '0) && (occupancy < DEPTH_V);
    assign resp_ok    = inflight_q && !fifo_under_flow;
    assign resp_retry = inflight_q && fifo_under_flow;
    assign head_valid = (count_q != '0);
    assign head_last  = buf_last_q[rd_ptr_q];
    assign pop        = head_valid && m_ready;

    assign fifo_rd_n = !rd_strobe;
    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign uf_cnt    = uf_cnt_q;
    assign m_valid   = head_valid;
    assign m_last    = head_valid && head_last;
    assign m_data    = head_valid ? buf_data_q[rd_ptr_q] : '0;

    // Next-state logic: burst sequencing plus issue/delivery/retry bookkeeping.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        to_issue_d   = to_issue_q;
        to_deliver_d = to_deliver_q;
        uf_cnt_d     = uf_cnt_q;
        inflight_d   = rd_strobe;

        if (rd_strobe) begin
            to_issue_d = to_issue_d - LEN_WIDTH'(1);
        end
        if (resp_retry) begin
            to_issue_d = to_issue_d + LEN_WIDTH'(1);
            if (uf_cnt_q != 8'hFF) begin
                uf_cnt_d = uf_cnt_q + 8'd1;
            end
        end
        if (resp_ok) begin
            to_deliver_d = to_deliver_q - LEN_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    to_issue_d   = req_len;
                    to_deliver_d = req_len;
                    uf_cnt_d     = '0;
                    state_d      = (req_len == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                // The final byte can already be at the head and accepted in this cycle.
                if ((to_issue_q == '0) && !inflight_q) begin
                    state_d = (pop && head_last) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && head_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output buffer next-state: push accepted responses, pop on downstream accept.
    always_comb begin
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (resp_ok) begin
            buf_data_d[wr_ptr_q] = fifo_data;
            buf_last_d[wr_ptr_q] = (to_deliver_q == LEN_WIDTH'(1));
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(resp_ok) - CNT_W'(pop);
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q      <= ST_IDLE;
            to_issue_q   <= '0;
            to_deliver_q <= '0;
            inflight_q   <= 1'b0;
            uf_cnt_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            to_issue_q   <= to_issue_d;
            to_deliver_q <= to_deliver_d;
            inflight_q   <= inflight_d;
            uf_cnt_q     <= uf_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Buffer storage register.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the cleared count marks every entry empty and outputs are gated.
        buf_data_q <= buf_data_d;
        buf_last_q <= buf_last_d;
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: a behavioural FIFO responder,
// a byte-level scoreboard and directed plus randomized bursts.
module tb_fifo_burst_reader;

    localparam int BD = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [4:0] req_len;
    logic       req_ready;
    logic       fifo_rd_n;
    logic [7:0] fifo_data;
    logic       fifo_under_flow;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
    logic       done;
    logic [7:0] uf_cnt;

    fifo_burst_reader dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_len         (req_len),
        .req_ready       (req_ready),
        .fifo_rd_n       (fifo_rd_n),
        .fifo_data       (fifo_data),
        .fifo_under_flow (fifo_under_flow),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .m_last          (m_last),
        .busy            (busy),
        .done            (done),
        .uf_cnt          (uf_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_err = 0;
    int cyc = 0, n_acc = 0, acc_cyc = 0;
    int n_strobe = 0, first_strobe_cyc = -1, last_strobe_cyc = 0;
    int first_mv_cyc = -1, n_mvalid = 0, n_busy = 0;
    int n_deliv = 0, last_acc_cyc = 0, n_got = 0, uf_seen = 0;
    int n_done = 0, done_cyc = 0, done_base = 0;
    int ready_mode = 0;
    bit rd_seen = 0, stall_prev = 0, prev_done = 0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;

    logic [7:0] fifo_q[$];
    logic [7:0] late_q[$];
    exp_t       exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Sampled at the falling edge: bookkeeping and per-cycle stream checks.
    task automatic monitor();
        exp_t e;
        if (rst) begin
            rd_seen    = 0;
            stall_prev = 0;
            prev_done  = 0;
            return;
        end
        if (req_valid && req_ready) begin
            n_acc++;
            acc_cyc = cyc;
        end
        if (busy) check("req_ready_low_while_busy", 32'(req_ready), 32'(0));
        rd_seen = !fifo_rd_n;
        if (rd_seen) begin
            check("strobe_only_while_busy", 32'(busy), 32'(1));
            n_strobe++;
            if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
            last_strobe_cyc = cyc;
        end
        if (busy) n_busy++;
        if (m_valid) begin
            n_mvalid++;
            if (first_mv_cyc < 0) first_mv_cyc = cyc;
        end
        if (stall_prev) begin
            check("hold_m_valid", 32'(m_valid), 32'(1));
            check("hold_m_data", 32'(m_data), 32'(prev_data));
            check("hold_m_last", 32'(m_last), 32'(prev_last));
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_byte", 32'(m_valid), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("m_data", 32'(m_data), 32'(e.data));
                check("m_last", 32'(m_last), 32'(e.last));
            end
            n_deliv++;
            last_acc_cyc = cyc;
        end
        check("occupancy_le_depth", 32'((n_got - n_deliv) <= BD), 32'(1));
        if (done) begin
            check("done_single_cycle", 32'(prev_done), 32'(0));
            n_done++;
            done_cyc = cyc;
        end
        prev_done  = done;
        stall_prev = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
    endtask

    // FIFO model: answers a strobe one cycle later; garbage when no strobe was made.
    task automatic respond();
        if (rd_seen) begin
            if (fifo_q.size() == 0) begin
                fifo_under_flow = 1'b1;
                fifo_data       = 8'($urandom);
                uf_seen++;
            end else begin
                fifo_under_flow = 1'b0;
                fifo_data       = fifo_q.pop_front();
                n_got++;
            end
        end else begin
            fifo_under_flow = 1'($urandom_range(0, 1));
            fifo_data       = 8'($urandom);
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        respond();
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic last, input bit preload);
        exp_t e;
        e.data = b;
        e.last = last;
        exp_q.push_back(e);
        if (preload) fifo_q.push_back(b);
        else late_q.push_back(b);
    endtask

    task automatic add_burst(input int len, input int preload, input bit rnd, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = rnd ? 8'($urandom) : base + 8'(i);
            expect_byte(b, (i == len - 1), (i < preload));
        end
    endtask

    task automatic flush_late();
        while (late_q.size() > 0) fifo_q.push_back(late_q.pop_front());
    endtask

    task automatic send_req(input int len);
        int a0;
        check("req_ready_in_idle", 32'(req_ready), 32'(1));
        a0               = n_acc;
        done_base        = n_done;
        first_strobe_cyc = -1;
        first_mv_cyc     = -1;
        req_valid        = 1'b1;
        req_len          = 5'(len);
        step();
        req_valid        = 1'b0;
        check("req_accepted", 32'(n_acc - a0), 32'(1));
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (n_done == done_base && k < budget) begin
            step();
            k++;
        end
        check("done_seen", 32'(n_done - done_base), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, dv0, u0, b0, mv0, a0, k, len, pre;
        rst             = 1'b1;
        req_valid       = 1'b0;
        req_len         = '0;
        m_ready         = 1'b1;
        fifo_data       = '0;
        fifo_under_flow = 1'b0;
        repeat (2) step();

        // Reset values.
        check("rst_fifo_rd_n", 32'(fifo_rd_n), 32'(1));
        check("rst_req_ready", 32'(req_ready), 32'(1));
        check("rst_m_valid", 32'(m_valid), 32'(0));
        check("rst_m_last", 32'(m_last), 32'(0));
        check("rst_m_data", 32'(m_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_uf_cnt", 32'(uf_cnt), 32'(0));
        rst = 1'b0;
        repeat (2) step();

        // 1: four preloaded bytes, downstream always ready.
        add_burst(4, 4, 0, 8'h10);
        s0 = n_strobe; dv0 = n_deliv;
        send_req(4);
        wait_done(50);
        repeat (3) step();
        check("t1_strobes", 32'(n_strobe - s0), 32'(4));
        check("t1_consecutive", 32'(last_strobe_cyc - first_strobe_cyc), 32'(3));
        check("t1_accept_to_strobe", 32'(first_strobe_cyc - acc_cyc), 32'(1));
        check("t1_strobe_to_valid", 32'(first_mv_cyc - first_strobe_cyc), 32'(2));
        check("t1_done_after_last", 32'(done_cyc - last_acc_cyc), 32'(1));
        check("t1_done_once", 32'(n_done - done_base), 32'(1));
        check("t1_delivered", 32'(n_deliv - dv0), 32'(4));
        check("t1_uf_cnt", 32'(uf_cnt), 32'(0));

        // 2: eight bytes with downstream stalled, then released.
        ready_mode = 2; m_ready = 1'b0;
        add_burst(8, 8, 0, 8'h20);
        s0 = n_strobe; dv0 = n_deliv;
        send_req(8);
        repeat (12) step();
        check("t2_strobes_stalled", 32'(n_strobe - s0), 32'(4));
        check("t2_rd_n_idle", 32'(fifo_rd_n), 32'(1));
        check("t2_none_accepted", 32'(n_deliv - dv0), 32'(0));
        ready_mode = 0; m_ready = 1'b1;
        wait_done(100);
        check("t2_strobes_total", 32'(n_strobe - s0), 32'(8));
        check("t2_delivered", 32'(n_deliv - dv0), 32'(8));
        check("t2_all_expected_seen", 32'(exp_q.size()), 32'(0));

        // 3: empty FIFO, bytes arrive late; underflows retried.
        expect_byte(8'hA5, 1'b0, 0);
        expect_byte(8'h5A, 1'b1, 0);
        u0 = uf_seen; dv0 = n_deliv;
        send_req(2);
        repeat (3) step();
        flush_late();
        wait_done(100);
        check("t3_uf_cnt", 32'(uf_cnt), 32'(sat255(uf_seen - u0)));
        check("t3_delivered", 32'(n_deliv - dv0), 32'(2));
        mv0 = n_mvalid;
        repeat (4) step();
        check("t3_no_extra_valid", 32'(n_mvalid - mv0), 32'(0));

        // 4: zero-length burst.
        s0 = n_strobe; b0 = n_busy; mv0 = n_mvalid;
        send_req(0);
        wait_done(10);
        repeat (3) step();
        check("t4_no_strobe", 32'(n_strobe - s0), 32'(0));
        check("t4_busy_cycles", 32'(n_busy - b0), 32'(1));
        check("t4_done_latency", 32'(done_cyc - acc_cyc), 32'(1));
        check("t4_no_valid", 32'(n_mvalid - mv0), 32'(0));

        // 5: reset in the middle of a burst, then a fresh burst.
        add_burst(6, 6, 0, 8'h40);
        s0 = n_strobe;
        send_req(6);
        k = 0;
        while (n_strobe - s0 < 3 && k < 30) begin
            step();
            k++;
        end
        check("t5_three_strobes", 32'(n_strobe - s0), 32'(3));
        #1 rst = 1'b1;
        #1;
        check("t5_rst_fifo_rd_n", 32'(fifo_rd_n), 32'(1));
        check("t5_rst_m_valid", 32'(m_valid), 32'(0));
        check("t5_rst_busy", 32'(busy), 32'(0));
        check("t5_rst_done", 32'(done), 32'(0));
        fifo_q.delete(); late_q.delete(); exp_q.delete();
        repeat (2) step();
        rst = 1'b0;
        n_got = n_deliv;
        step();
        add_burst(2, 2, 1, 8'h00);
        dv0 = n_deliv;
        send_req(2);
        wait_done(50);
        repeat (3) step();
        check("t5_delivered", 32'(n_deliv - dv0), 32'(2));
        check("t5_all_expected_seen", 32'(exp_q.size()), 32'(0));
        check("t5_idle_no_valid", 32'(m_valid), 32'(0));

        // 6: second request held during a burst is taken only back in IDLE.
        ready_mode = 1;
        add_burst(5, 5, 1, 8'h00);
        add_burst(3, 3, 1, 8'h00);
        a0 = n_acc; dv0 = n_deliv;
        send_req(5);
        req_valid = 1'b1;
        req_len   = 5'd3;
        k = 0;
        while (n_acc - a0 < 2 && k < 300) begin
            step();
            k++;
        end
        req_valid = 1'b0;
        check("t6_second_accepted", 32'(n_acc - a0), 32'(2));
        check("t6_first_done_first", 32'(n_done - done_base), 32'(1));
        check("t6_accept_after_done", 32'(acc_cyc - done_cyc), 32'(1));
        done_base = n_done;
        wait_done(300);
        check("t6_delivered", 32'(n_deliv - dv0), 32'(8));
        check("t6_all_expected_seen", 32'(exp_q.size()), 32'(0));

        // Randomized bursts with partial preload and random backpressure.
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(0, 31);
            pre = $urandom_range(0, len);
            add_burst(len, pre, 1, 8'h00);
            dv0 = n_deliv; u0 = uf_seen;
            send_req(len);
            repeat ($urandom_range(0, 6)) step();
            flush_late();
            wait_done(600);
            check("rnd_delivered", 32'(n_deliv - dv0), 32'(len));
            check("rnd_uf_cnt", 32'(uf_cnt), 32'(sat255(uf_seen - u0)));
            check("rnd_all_expected_seen", 32'(exp_q.size()), 32'(0));
        end

        // Underflow counter saturation on a long-starved burst.
        ready_mode = 0;
        expect_byte(8'hC3, 1'b1, 0);
        u0 = uf_seen;
        send_req(1);
        repeat (600) step();
        check("sat_uf_cnt_starved", 32'(uf_cnt), 32'(sat255(uf_seen - u0)));
        flush_late();
        wait_done(20);
        check("sat_uf_cnt_final", 32'(uf_cnt), 32'(sat255(uf_seen - u0)));
        check("sat_all_expected_seen", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
